// File: rtl/tff_count_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tff_count_pkg
// Brief    : Shared state encoding and direction constants for tff_count_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package tff_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : tff_count_pkg
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module   : tff_cell
// Brief    : Single T flip-flop with asynchronous active-low clear (Q -> 0).
// Revision : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic t,
    output logic q,
    output logic qn
);

    logic r_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_ctrl
// Brief    : Sequences a bank of T cells as a loadable up/down counter with a
//            start/done handshake, hold and modulo wrap-around.
// Options  : TFF_COUNT_CTRL_ABORT_EN adds an abort input (LOAD/RUN -> IDLE).
// Revision : 1.0 - initial release
// ============================================================================
module tff_count_ctrl
    import tff_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             hold,
`ifdef TFF_COUNT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic             r_start;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_term_val;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_up_en;
    logic [WIDTH-1:0] w_dn_en;
    logic             w_abort;
    logic             w_at_term;

`ifdef TFF_COUNT_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_at_term = (w_q == r_term_val);

    // Bit i toggles on a step when all lower bits are 1 (up) or all 0 (down).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        localparam logic [WIDTH-1:0] c_low_mask = ~({WIDTH{1'b1}} << gi);

        assign w_up_en[gi] = &(w_q  | ~c_low_mask);
        assign w_dn_en[gi] = &(w_qn | ~c_low_mask);

        tff_cell u_cell (
            .clk   (clk),
            .clr_n (clr_n),
            .t     (w_t[gi]),
            .q     (w_q[gi]),
            .qn    (w_qn[gi])
        );
    end

    always_comb begin
        w_t = '0;
        if (!w_abort) begin
            case (r_state)
                LOAD: w_t = w_q ^ r_load_val;
                RUN: begin
                    if (!w_at_term && !hold) begin
                        case (r_dir)
                            DIR_UP:   w_t = w_up_en;
                            DIR_DOWN: w_t = w_dn_en;
                            default:  w_t = '0;
                        endcase
                    end
                end
                default: w_t = '0;
            endcase
        end
    end

    // start is captured one edge before IDLE acts on it, which sets the
    // k+1 busy / k+2 count latency; operands are frozen at that capture.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_dir      <= 1'b0;
            r_load_val <= '0;
            r_term_val <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end else if (start) begin
                        r_start    <= 1'b1;
                        r_dir      <= dir;
                        r_load_val <= load_val;
                        r_term_val <= term_val;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_at_term) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count = w_q;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : tff_count_ctrl
`default_nettype wire

// File: doc/tff_count_ctrl.md
Name: tff_count_ctrl

Overview:
- Controller that sequences a bank of WIDTH T flip-flops as a synchronous loadable up/down counter.
- It generates every per-bit T input itself, and the bank of T cells is instantiated inside the block.
- It handles:
  - a start/done handshake;
  - loading a preset value through a toggle mask, so the cells need no async preset or clear;
  - stepping the count towards a terminal value, with hold and wrap-around.
- It sits between a host sequencer and the T-cell datapath, and owns all T-cell control.

Parameters:
- WIDTH, 4, number of T cells / counter bits (min 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- dir  input  1  1 = count up, 0 = count down; latched when start is accepted.
- load_val  input  WIDTH  preset value; latched when start is accepted.
- term_val  input  WIDTH  terminal value; latched when start is accepted.
- hold  input  1  freezes the count while high, in RUN only.
- count  output  WIDTH  T-cell bank state (the Q vector).
- busy  output  1  high in LOAD, RUN and DONE.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (clr_n low, asynchronous, takes effect immediately, including mid-run):
  - state = IDLE; count = 0; busy = 0; done = 0;
  - latched dir, load_val and term_val = 0.
- States are IDLE, LOAD, RUN, DONE.
- IDLE:
  - all T inputs = 0;
  - on start = 1, latch dir, load_val and term_val, then go to LOAD.
- LOAD (exactly 1 cycle):
  - T vector = count XOR load_val, so after the edge count = load_val;
  - next state is RUN; hold is ignored.
- RUN:
  - If count == term_val: T vector = 0 and next state is DONE. The compare has priority over hold.
  - Else if hold = 1: T vector = 0 and the state stays RUN.
  - Else count steps by one:
    - up: T[0] = 1, T[i] = AND of count[i-1:0];
    - down: T[0] = 1, T[i] = AND of ~count[i-1:0].
- Arithmetic is modulo 2^WIDTH:
  - up from all-ones wraps to 0;
  - down from 0 wraps to all-ones;
  - a run passes through the wrap if term_val lies "behind" load_val.
- DONE (1 cycle): done = 1, count is frozen, next state is IDLE.
- start outside IDLE is ignored.
- Changes to dir, load_val or term_val after acceptance are ignored.
- Latency:
  - start sampled at edge k gives count = load_val after edge k+2;
  - busy rises after edge k+1;
  - each non-held RUN cycle is one step;
  - done is high for the cycle after the edge on which RUN detects equality.
- If load_val == term_val: LOAD, then one RUN cycle with no step, then DONE.
- count holds its final value in IDLE until the next LOAD.

Optional Feature:
- Macro: TFF_COUNT_CTRL_ABORT_EN.
- Defined:
  - adds input abort (1 bit);
  - abort = 1 in LOAD or RUN sends the state to IDLE at the next edge;
  - T vector = 0 during that cycle, so count freezes; done is not asserted;
  - abort has priority over the term compare and over hold;
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port, and the FSM is exactly as above.

Decomposition:
- Package tff_count_pkg holds:
  - the state enum with encodings IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  - the constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- Sub-module tff_cell: one T flip-flop with clk, clr_n (async active-low, Q -> 0), T, Q and Qn.
  - The controller instantiates WIDTH of these in a generate loop.
  - The T-vector logic and FSM live in tff_count_ctrl.

Test Plan:
- Reset value: WIDTH = 4, clr_n low at any time → count = 0, busy = 0, done = 0 without waiting for a clk edge.
- Up run: load_val = 3, term_val = 7, dir = 1, start pulsed.
  - count goes 3, 4, 5, 6, 7 on consecutive cycles.
  - Exactly one done pulse follows, then busy = 0; count stays 7.
- Down run through wrap: load_val = 1, term_val = 14, dir = 0.
  - count goes 1, 0, 15, 14, then done.
  - Total run length is 4 RUN cycles plus LOAD and DONE.
- Hold: up run 0 → 5 with hold = 1 for 3 cycles while count = 2.
  - count stays 2 for 3 cycles, then resumes; done occurs 3 cycles later than in the unheld run.
- Equal preset and start while busy: load_val = term_val = 9 → count = 9, a single RUN cycle, done.
  - A second start pulse during RUN is ignored, and no second run occurs.
- Reset mid-run: clr_n low while count = 4 of a 0 → 10 run → immediate count = 0 and IDLE.
  - After release, no done pulse occurs until a new start.
  - With TFF_COUNT_CTRL_ABORT_EN: abort at count = 4 → count stays 4, IDLE, done never asserted.
